// File: rtl/multi_axis_cf.sv
// multi_axis_cf: per-axis complementary filter over NCH channels.
// One sample is processed one channel per cycle through a shared datapath.
// Each channel keeps two estimates:
//   est  - fused angle estimate
//   gint - pure gyro-integrated angle
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   gyro_i, acc_i             packed signed gyro rates / accel angles (ch c at [c*DW +: DW])
//   mode_i                    00 fused, 01 gyro-only, 10 accel-only, 11 hold
//   clear_i                   synchronous clear of all estimates (honoured in IDLE only)
//   valid_in / ready_in       sample handshake; ready_in is combinational from state and clear_i
//   angle_o, gyro_o           packed est / gint registers
//   valid_out / out_ready     result handshake
//
// Optional feature: define MULTI_AXIS_CF_SAT_EN to saturate est/gint updates
// to DW bits. Without it, updates wrap in two's complement.
module multi_axis_cf #(
  parameter int unsigned NCH      = 3,
  parameter int unsigned DW       = 16,
  parameter int unsigned GYRO_SH  = 4,
  parameter int unsigned ALPHA_SH = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH*DW-1:0] gyro_i,
  input  logic [NCH*DW-1:0] acc_i,
  input  logic [1:0]        mode_i,
  input  logic              clear_i,
  input  logic              valid_in,
  output logic              ready_in,
  output logic [NCH*DW-1:0] angle_o,
  output logic [NCH*DW-1:0] gyro_o,
  output logic              valid_out,
  input  logic              out_ready
);

  localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned EW = DW + 2;

  localparam logic [1:0] M_FUSED = 2'b00;
  localparam logic [1:0] M_GYRO  = 2'b01;
  localparam logic [1:0] M_ACC   = 2'b10;

  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

  state_t               state, state_n;
  logic                 valid_out_n;
  logic                 accept, calc_en, clr;
  logic [CW-1:0]        ch;
  logic [NCH*DW-1:0]    gyro_q, acc_q;
  logic [1:0]           mode_q;
  logic signed [DW-1:0] est  [NCH];
  logic signed [DW-1:0] gint [NCH];

  // Shared per-channel datapath signals
  logic signed [DW-1:0] gyro_c, acc_c, est_c, gint_c;
  logic signed [DW-1:0] est_n, gint_n;
  logic signed [EW-1:0] gyro_x, acc_x, est_x, gint_x;
  logic signed [EW-1:0] rate, g, diff, fused, gsum;

  // Reduce a DW+2 bit result back to DW bits (saturate or wrap)
  function automatic logic signed [DW-1:0] fit(input logic signed [EW-1:0] v);
`ifdef MULTI_AXIS_CF_SAT_EN
    logic signed [EW-1:0] smax, smin;
    smax = {3'b000, {(DW-1){1'b1}}};
    smin = {3'b111, {(DW-1){1'b0}}};
    if (v > smax)      return smax[DW-1:0];
    else if (v < smin) return smin[DW-1:0];
    else               return v[DW-1:0];
`else
    return v[DW-1:0];
`endif
  endfunction

  assign ready_in = (state == IDLE) && !clear_i;

  // Continuous readout of the estimate registers
  for (genvar c = 0; c < NCH; c++) begin : g_out
    assign angle_o[c*DW +: DW] = est[c];
    assign gyro_o[c*DW +: DW]  = gint[c];
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Next-state and control decode
  always_comb begin
    state_n     = state;
    valid_out_n = 1'b0;
    accept      = 1'b0;
    calc_en     = 1'b0;
    clr         = 1'b0;
    case (state)
      IDLE: begin
        if (clear_i) begin
          clr = 1'b1;
        end else if (valid_in) begin
          accept  = 1'b1;
          state_n = CALC;
        end
      end
      CALC: begin
        calc_en = 1'b1;
        if (ch == CW'(NCH - 1)) state_n = OUT;
      end
      OUT: begin
        // valid_out rises one cycle after entering OUT; leave only once it was seen
        if (valid_out && out_ready) begin
          state_n = IDLE;
        end else begin
          valid_out_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Channel select and sign-extended operands
  always_comb begin
    gyro_c = gyro_q[ch*DW +: DW];
    acc_c  = acc_q[ch*DW +: DW];
    est_c  = est[ch];
    gint_c = gint[ch];
    gyro_x = {{2{gyro_c[DW-1]}}, gyro_c};
    acc_x  = {{2{acc_c[DW-1]}}, acc_c};
    est_x  = {{2{est_c[DW-1]}}, est_c};
    gint_x = {{2{gint_c[DW-1]}}, gint_c};
  end

  // Filter arithmetic for the selected channel
  always_comb begin
    rate   = gyro_x >>> GYRO_SH;
    g      = est_x + rate;
    gsum   = gint_x + rate;
    diff   = acc_x - g;
    fused  = g + (diff >>> ALPHA_SH);
    gint_n = fit(gsum);
    case (mode_q)
      M_FUSED: est_n = fit(fused);
      M_GYRO:  est_n = fit(g);
      M_ACC:   est_n = acc_c;
      default: est_n = est_c;
    endcase
  end

  // Capture, per-channel update, clear and result valid
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_out <= 1'b0;
      ch        <= '0;
      gyro_q    <= '0;
      acc_q     <= '0;
      mode_q    <= '0;
      for (int c = 0; c < NCH; c++) begin
        est[c]  <= '0;
        gint[c] <= '0;
      end
    end else begin
      valid_out <= valid_out_n;
      if (accept) begin
        gyro_q <= gyro_i;
        acc_q  <= acc_i;
        mode_q <= mode_i;
        ch     <= '0;
      end else if (calc_en) begin
        est[ch]  <= est_n;
        gint[ch] <= gint_n;
        ch       <= ch + CW'(1);
      end
      if (clr) begin
        for (int c = 0; c < NCH; c++) begin
          est[c]  <= '0;
          gint[c] <= '0;
        end
      end
    end
  end

endmodule

// File: doc/multi_axis_cf.md
MULTI_AXIS_CF -- requirements
Module: multi_axis_cf

Interface
REQ-001 SHALL have parameter NCH, default 3, number of axes/channels (1..8).
REQ-002 SHALL have parameter DW, default 16, signed sample/angle width.
REQ-003 SHALL have parameter GYRO_SH, default 4, arithmetic right shift applied to gyro rate per sample.
REQ-004 SHALL have parameter ALPHA_SH, default 5, correction gain 2^-ALPHA_SH toward the accel angle.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port gyro_i  input  NCH*DW  packed signed gyro rates; channel c is bits [c*DW +: DW].
REQ-008 SHALL have port acc_i  input  NCH*DW  packed signed accel-derived angles, same packing.
REQ-009 SHALL have port mode_i  input  2  00 fused, 01 gyro-only, 10 accel-only, 11 hold.
REQ-010 SHALL have port clear_i  input  1  synchronous clear of all estimates.
REQ-011 SHALL have port valid_in  input  1  sample valid.
REQ-012 SHALL have port ready_in  output  1  block can accept a sample.
REQ-013 SHALL have port angle_o  output  NCH*DW  packed fused angle estimates.
REQ-014 SHALL have port gyro_o  output  NCH*DW  packed pure gyro-integrated angles.
REQ-015 SHALL have port valid_out  output  1  result valid.
REQ-016 SHALL have port out_ready  input  1  downstream accepts result.

Function
REQ-017 SHALL implement FSM IDLE, CALC, OUT; ready_in = 1 only in IDLE with clear_i = 0.
REQ-018 SHALL accept a sample when valid_in & ready_in, register gyro_i, acc_i and mode_i, clear channel counter, and go to CALC.
REQ-019 SHALL process one channel per CALC cycle, channels 0..NCH-1 in order, through one shared datapath.
REQ-020 SHALL compute g = est[c] + (gyro[c] >>> GYRO_SH) and gint[c] += gyro[c] >>> GYRO_SH, in DW+2 bits.
REQ-021 SHALL set est[c] per mode: fused g + ((acc[c] - g) >>> ALPHA_SH); gyro-only g; accel-only acc[c]; hold unchanged.
REQ-022 SHALL update gint[c] in every mode, including hold.
REQ-023 SHALL go to OUT after channel NCH-1 and assert valid_out, so valid_out rises NCH+1 cycles after the accepting edge.
REQ-024 SHALL hold angle_o, gyro_o and valid_out stable in OUT until out_ready = 1, then return to IDLE.
REQ-025 SHALL, when out_ready = 1 in OUT, deassert valid_out on the next edge; no back-to-back acceptance in that same cycle.
REQ-026 SHALL, when clear_i = 1 in IDLE, zero all est and gint and not accept a simultaneous valid_in.
REQ-027 SHALL ignore clear_i in CALC and OUT.
REQ-028 SHALL drive angle_o and gyro_o continuously from the est and gint registers.

Reset
REQ-029 SHALL on rst = 0 force IDLE, zero est, gint, channel counter and captured inputs, drive valid_out = 0 and ready_in = 1, and drive angle_o = gyro_o = 0.
REQ-030 SHALL, on reset mid-CALC or mid-OUT, abandon the sample with no partial result emitted.

Configuration
REQ-031 SHALL, with macro MULTI_AXIS_CF_SAT_EN defined, saturate every est/gint result to [-2^(DW-1), 2^(DW-1)-1].
REQ-032 SHALL, without MULTI_AXIS_CF_SAT_EN, truncate results to DW bits (two's-complement wrap).

Verification (NCH=3, DW=16, GYRO_SH=4, ALPHA_SH=5)
REQ-033 SHALL check reset: rst low mid-CALC -> valid_out=0, ready_in=1, angle_o=gyro_o=0, and no result appears afterwards.
REQ-034 SHALL check gyro-only: mode 01, gyro ch0=160, two samples -> angle ch0 = 10 then 20; each valid_out 4 cycles after accept; gyro_o ch0 matches.
REQ-035 SHALL check accel-only then fused: mode 10, acc ch1=3200 -> angle ch1=3200; then mode 00, gyro 0, acc ch1=0 -> 3100; gyro_o ch1 remains 0.
REQ-036 SHALL check fused from zero: gyro 0, acc ch2=3200 -> 100, then 196.
REQ-037 SHALL check saturation: mode 10, acc ch0=32767, then mode 01, gyro ch0=32767 -> 32767 with macro; -30722 without.
REQ-038 SHALL check handshake: out_ready=0 for 10 cycles -> valid_out and data held, ready_in=0, and valid_in ignored; clear_i plus valid_in in IDLE -> outputs 0 and no sample accepted.
